// File: rtl/sort_pkg.sv
// Shared types and constants for the sort circuit's memory target.
package sort_pkg;

  localparam int DEF_ADDR_WDTH = 4;
  localparam int DEF_DATA_WDTH = 32;
  localparam int DEF_RESP_WDTH = 1;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

  typedef enum logic {R_IDLE, R_DATA} rd_state_t;
  typedef enum logic {W_IDLE, W_RESP} wr_state_t;

endpackage

// File: rtl/sort_mem_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used to throttle the memory target's readies.
module sort_mem_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= SEED;
    end else if (en) begin
      q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end
  end

endmodule

// File: rtl/sort_mem_slave.sv
// Word-addressed memory target for the sorter's AR/R and AW/W/B channels.
// Define SORT_MEM_WAIT_EN to add LFSR-driven backpressure on all readies.
module sort_mem_slave
  import sort_pkg::*;
#(
  parameter int         ADDR_WDTH = DEF_ADDR_WDTH,
  parameter int         DATA_WDTH = DEF_DATA_WDTH,
  parameter int         RESP_WDTH = DEF_RESP_WDTH,
  parameter int         DEPTH     = 16,
  parameter logic [7:0] WAIT_SEED = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ar_valid,
  output logic                 ar_ready,
  input  logic [ADDR_WDTH-1:0] ar_address,
  output logic                 r_valid,
  input  logic                 r_ready,
  output logic [DATA_WDTH-1:0] r_data,
  output logic [RESP_WDTH-1:0] r_resp,
  input  logic                 aw_valid,
  output logic                 aw_ready,
  input  logic [ADDR_WDTH-1:0] aw_address,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [DATA_WDTH-1:0] w_data,
  output logic                 b_valid,
  input  logic                 b_ready,
  output logic [RESP_WDTH-1:0] b_resp
);

  localparam logic [ADDR_WDTH:0] DEPTH_L   = (ADDR_WDTH+1)'(DEPTH);
  localparam logic [7:0]         LFSR_SEED = (WAIT_SEED != 8'h00) ? WAIT_SEED : 8'h01;

  function automatic logic in_range(input logic [ADDR_WDTH-1:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  logic [DATA_WDTH-1:0] mem [DEPTH];

  rd_state_t rd_state, rd_next;
  wr_state_t wr_state, wr_next;

  logic                 aw_got, w_got;
  logic [ADDR_WDTH-1:0] aw_addr_q, cur_addr;
  logic [DATA_WDTH-1:0] w_data_q, cur_data;
  logic                 ar_hs, aw_hs, w_hs, commit;
  logic                 rdy_en;

`ifdef SORT_MEM_WAIT_EN
  logic [7:0] lfsr_q;

  sort_mem_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .q   (lfsr_q)
  );

  assign rdy_en = lfsr_q[0];
`else
  assign rdy_en = (LFSR_SEED != 8'h00);
`endif

  assign ar_ready = !rst && rdy_en && (rd_state == R_IDLE);
  assign aw_ready = !rst && rdy_en && (wr_state == W_IDLE) && !aw_got;
  assign w_ready  = !rst && rdy_en && (wr_state == W_IDLE) && !w_got;
  assign r_valid  = (rd_state == R_DATA);
  assign b_valid  = (wr_state == W_RESP);

  assign ar_hs = ar_valid && ar_ready;
  assign aw_hs = aw_valid && aw_ready;
  assign w_hs  = w_valid && w_ready;

  // A captured half of the write takes priority over the live bus for that half.
  assign cur_addr = aw_got ? aw_addr_q : aw_address;
  assign cur_data = w_got ? w_data_q : w_data;
  assign commit   = (wr_state == W_IDLE) && (aw_got || aw_hs) && (w_got || w_hs);

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_hs) rd_next = R_DATA;
      R_DATA:  if (r_ready) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:  if (commit) wr_next = W_RESP;
      W_RESP:  if (b_ready) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= R_IDLE;
      r_data   <= '0;
      r_resp   <= '0;
    end else begin
      rd_state <= rd_next;
      if (ar_hs) begin
        if (in_range(ar_address)) begin
          r_data <= mem[ar_address];
          r_resp <= RESP_WDTH'(RESP_OKAY);
        end else begin
          r_data <= '0;
          r_resp <= RESP_WDTH'(RESP_ERR);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state  <= W_IDLE;
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      b_resp    <= '0;
    end else begin
      wr_state <= wr_next;
      if (commit) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        b_resp <= in_range(cur_addr) ? RESP_WDTH'(RESP_OKAY) : RESP_WDTH'(RESP_ERR);
      end else begin
        if (aw_hs) begin
          aw_got    <= 1'b1;
          aw_addr_q <= aw_address;
        end
        if (w_hs) begin
          w_got    <= 1'b1;
          w_data_q <= w_data;
        end
      end
    end
  end

  // Storage is deliberately left out of reset so committed data survives it.
  always_ff @(posedge clk) begin
    if (!rst && commit && in_range(cur_addr)) begin
      mem[cur_addr] <= cur_data;
    end
  end

endmodule
